// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-0 register-file responder for the accelerometer link.
// Ports:
//   ck, nRST           system clock, asynchronous active-low reset
//   sclk, nCS, mosi    SPI pins from the controller (asynchronous, synchronized here)
//   miso, miso_oe      serial read data and its drive-enable
//   busy               transaction in progress
//   wr_pulse/addr/data one-ck strobe and payload of a committed register write
//   cmd_err            one-ck strobe on an unknown instruction byte
module spi_accel_responder #(
    parameter int ADDR_W = 6,
    parameter int RO_TOP = 3
) (
    input  logic              ck,
    input  logic              nRST,
    input  logic              sclk,
    input  logic              nCS,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cmd_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RO_LIM = ADDR_W'(RO_TOP);

    typedef enum logic [2:0] {IDLE, INSTR, ADDR, RD, WR, SKIP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sclk_sync_q, ncs_sync_q, mosi_sync_q;
    logic              sclk_prev_q, ncs_prev_q;
    logic [2:0]        bit_q;
    logic [6:0]        shift_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              is_rd_q, load_q;
    logic              miso_q, miso_oe_q, wr_pulse_q, cmd_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        regs_q [DEPTH];

    logic sclk_s, ncs_s, mosi_s;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic byte_done, instr_ok, shifting, abort;
    logic [7:0] byte_in;

    function automatic logic [7:0] rst_val(input int i);
        return i == 0 ? 8'hAD : i == 1 ? 8'h1D : i == 2 ? 8'hF2 : i == 3 ? 8'h01 : 8'h00;
    endfunction

    assign sclk_s    = sclk_sync_q[1];
    assign ncs_s     = ncs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign byte_in   = {shift_q, mosi_s};
    assign byte_done = sclk_rise && bit_q == 3'd7;
    assign instr_ok  = byte_in == 8'h0B || byte_in == 8'h0A;
    assign shifting  = state_q inside {INSTR, ADDR, RD, WR};
    // nCS rise outranks any sclk edge seen in the same cycle
    assign abort     = state_q != IDLE && ncs_rise;

    // nCS synchronizer resets to "selected" so a frame already running at
    // reset release produces no fall and is ignored until nCS returns high.
    always_ff @(posedge ck or negedge nRST) begin
        if (!nRST) begin
            sclk_sync_q <= 2'b00;
            ncs_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            ncs_sync_q  <= {ncs_sync_q[0], nCS};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    always_ff @(posedge ck or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ncs_fall ? INSTR : IDLE;
            INSTR:   state_d = byte_done ? (instr_ok ? ADDR : SKIP) : INSTR;
            ADDR:    state_d = byte_done ? (is_rd_q ? RD : WR) : ADDR;
            default: state_d = state_q;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        busy     = state_q != IDLE;
        miso     = miso_q;
        miso_oe  = miso_oe_q;
        wr_pulse = wr_pulse_q;
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
        cmd_err  = cmd_err_q;
    end

    // load_q marks that the next sclk fall must fetch a fresh byte from
    // regs_q[addr_q]; it is set at the end of the address byte and after
    // every completed read byte, which gives burst reads for free.
    always_ff @(posedge ck or negedge nRST) begin
        if (!nRST) begin
            bit_q      <= 3'd0;
            shift_q    <= 7'd0;
            tx_q       <= 8'd0;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
            load_q     <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            cmd_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= rst_val(i);
        end else begin
            wr_pulse_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            if (abort) begin
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
                load_q    <= 1'b0;
            end else if (state_q == IDLE && ncs_fall) begin
                bit_q <= 3'd0;
            end else if (sclk_rise && shifting) begin
                bit_q   <= bit_q + 3'd1;
                shift_q <= byte_in[6:0];
                if (bit_q == 3'd7) begin
                    case (state_q)
                        INSTR: begin
                            is_rd_q   <= byte_in == 8'h0B;
                            cmd_err_q <= !instr_ok;
                        end
                        ADDR: begin
                            addr_q <= byte_in[ADDR_W-1:0];
                            load_q <= is_rd_q;
                        end
                        RD: begin
                            addr_q <= addr_q + 1'b1;
                            load_q <= 1'b1;
                        end
                        WR: begin
                            addr_q <= addr_q + 1'b1;
                            if (addr_q > RO_LIM) begin
                                regs_q[addr_q] <= byte_in;
                                wr_pulse_q     <= 1'b1;
                                wr_addr_q      <= addr_q;
                                wr_data_q      <= byte_in;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall && state_q == RD) begin
                if (load_q) begin
                    miso_q    <= regs_q[addr_q][7];
                    tx_q      <= {regs_q[addr_q][6:0], 1'b0};
                    miso_oe_q <= 1'b1;
                    load_q    <= 1'b0;
                end else begin
                    miso_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI mode-0 responder model of the accelerometer's register interface, the far end of the link driven by the read-register controller. It oversamples `sclk`, `nCS` and `mosi` on the system clock and decodes the three-byte read (0x0B) and write (0x0A) transactions with address auto-increment. It holds a small register file and shifts read data out on `miso`. It serves as the bench partner for the controller and as an on-chip loopback target.

## Interface
- `ADDR_W`, 6, register address width; the register file holds 2^ADDR_W bytes.
- `RO_TOP`, 3, highest read-only address; addresses 0..RO_TOP ignore writes.

- `ck`  in  1  system clock, single clock domain.
- `nRST`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the controller, idle low.
- `nCS`  in  1  chip select, active low.
- `mosi`  in  1  serial data from the controller, MSB first.
- `miso`  out  1  serial data to the controller, MSB first; 0 when not driving.
- `miso_oe`  out  1  high while a read data byte is being shifted out.
- `busy`  out  1  high while a transaction is in progress (state ≠ IDLE).
- `wr_pulse`  out  1  one-`ck` strobe when a register write commits.
- `wr_addr`  out  ADDR_W  address of the committed write; valid with `wr_pulse`.
- `wr_data`  out  8  data of the committed write; valid with `wr_pulse`.
- `cmd_err`  out  1  one-`ck` strobe when an unknown instruction byte is received.

## Operation
- `sclk`, `nCS` and `mosi` each pass through a 2-FF synchronizer. Rise and fall of `sclk` are detected from the synchronized value and its previous sample.
- `mosi` is sampled on detected `sclk` rise. `miso` updates on detected `sclk` fall.
- Bit counter runs 0..7 within each byte.
- States:
  - IDLE: `nCS` high; waiting for it to fall.
  - INSTR: shifting in the instruction byte.
  - ADDR: shifting in the address byte.
  - RD: shifting read data out.
  - WR: shifting write data in.
  - SKIP: ignoring the rest of the frame.
- Transitions:
  - IDLE→INSTR on synchronized `nCS` fall; the bit counter clears.
  - INSTR→ADDR after 8 rises, when the instruction is 0x0B or 0x0A.
  - INSTR→SKIP after 8 rises on any other instruction; `cmd_err` pulses once.
  - ADDR→RD or ADDR→WR after 8 rises. The address register takes the low ADDR_W bits of the byte; upper bits are ignored.
- RD:
  - On the first fall after the 16th rise: load `reg[addr]`, drive bit 7, assert `miso_oe`.
  - On each following fall: drive the next bit.
  - After the 8th rise of the byte: address increments and the next byte loads on the following fall (burst read).
- WR:
  - After the 8th rise of a data byte: if addr > RO_TOP, write `reg[addr]` and pulse `wr_pulse` with `wr_addr`/`wr_data`; otherwise drop the byte silently.
  - Address increments in both cases.
- Address increment wraps from 2^ADDR_W−1 to 0.
- SKIP: `miso` is 0, no writes.
- Any state→IDLE on synchronized `nCS` rise. A partial data byte is discarded; no write, no `wr_pulse`.
- Reset values:
  - Register file: `reg[0]`=0xAD, `reg[1]`=0x1D, `reg[2]`=0xF2, `reg[3]`=0x01, all others 0x00.
  - Outputs: `miso`=0, `miso_oe`=0, `busy`=0, `wr_pulse`=0, `wr_addr`=0, `wr_data`=0, `cmd_err`=0.
  - State is IDLE.
- `nRST` low mid-transaction: immediate return to reset values, including the register file. After `nRST` rises, the block waits for a fresh `nCS` fall; a frame already in progress (`nCS` low at reset release) is ignored until `nCS` goes high.

## Timing
- Pin-to-decision latency is 3 `ck` cycles: 2 synchronizer stages plus the edge register.
- `miso` changes 3–4 `ck` after the `sclk` pin falls.
- `sclk` high and low phases must each last ≥4 `ck` cycles. With a 10 ns `ck`, maximum `sclk` is 12.5 MHz.
- Setup from `nCS` fall to first `sclk` rise: ≥4 `ck`. Hold from last `sclk` fall to `nCS` rise: ≥4 `ck`.
- `wr_pulse` and `cmd_err` assert exactly one `ck` cycle after the 8th rise of the relevant byte is detected.
- `busy` rises 3 `ck` after the `nCS` pin falls and drops 3 `ck` after it rises.
- `miso_oe` drops on `nCS` rise detection or on entry to SKIP.
- Simultaneous `nCS` rise and `sclk` edge detected in the same cycle: `nCS` wins and the edge is ignored.

## Test plan
- Reset, then read 0x0B/0x00 for one byte: `miso` returns 0xAD, `miso_oe` high only during the data byte, `busy` 0 afterwards.
- Burst read 0x0B/0x00 for four bytes: 0xAD, 0x1D, 0xF2, 0x01. Repeat at addr 0x3F for two bytes: reg[0x3F] then 0xAD (wrap).
- Write 0x0A/0x10/0x5A, then read 0x10: one `wr_pulse` with `wr_addr`=0x10, `wr_data`=0x5A; read returns 0x5A.
- Write 0x0A/0x01/0xFF: no `wr_pulse`; a subsequent read of 0x01 returns 0x1D.
- Instruction 0x33: `cmd_err` pulses once, `miso` stays 0, no writes occur, `busy` drops after `nCS` rise.
- Abort cases:
  - `nCS` rises after 4 data bits of write 0x0A/0x20/0xC3: no `wr_pulse` and reg[0x20] stays 0x00.
  - `nRST` pulsed mid-read: outputs return to reset values, and the next read of 0x00 returns 0xAD.
